icache_refill_ctrl: RTL
=======================

ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 The block SHALL have parameter LINE_ADDR_LEN, default 3, meaning log2 of words per line (8 words).
REQ-002 The block SHALL have parameter SET_ADDR_LEN, default 4, meaning log2 of sets (16 sets, direct-mapped); TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, with ports as follows.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rd_req  in  1  core fetch request.
REQ-007 addr  in  30 [31:2]  fetch word address.
REQ-008 rd_data  out  32  fetched instruction, valid when rd_req && !miss.
REQ-009 miss  out  1  stall to core.
REQ-010 mem_rd_req  out  1  line refill request to backing memory.
REQ-011 mem_rd_addr  out  30 [31:2]  line-aligned refill address, low LINE_ADDR_LEN bits zero.
REQ-012 mem_rd_valid  in  1  one refill word beat.
REQ-013 mem_rd_data  in  32  refill word, ascending word order.

Function
REQ-014 Address split SHALL be addr = {tag, set, word}, word = low LINE_ADDR_LEN bits.
REQ-015 Storage SHALL be per set: valid bit, TAG_LEN tag, 2^LINE_ADDR_LEN x 32 data words.
REQ-016 FSM states SHALL be IDLE, REFILL, FILL_DONE.
REQ-017 hit SHALL be valid[set] && tag[set]==tag, combinational.
REQ-018 In IDLE, rd_req && hit: miss=0 and rd_data = data[set][word] in the same cycle (zero-latency hit).
REQ-019 In IDLE, rd_req && !hit: miss=1 same cycle; line address {tag,set} latched; next state REFILL.
REQ-020 miss SHALL be 1 in REFILL and FILL_DONE regardless of rd_req.
REQ-021 In REFILL, mem_rd_req SHALL be held 1 and mem_rd_addr SHALL equal latched line address; both stable until last beat.
REQ-022 Each mem_rd_valid beat in REFILL SHALL write mem_rd_data to data[latched set][beat counter] and increment beat counter (LINE_ADDR_LEN bits).
REQ-023 On the beat with counter = 2^LINE_ADDR_LEN-1: tag and valid written, counter wraps to 0, mem_rd_req drops next cycle, next state FILL_DONE.
REQ-024 FILL_DONE SHALL last one cycle then IDLE; the retried fetch hits in IDLE (miss-to-data = beats + 2 cycles minimum).
REQ-025 Changes of addr or rd_req during REFILL SHALL be ignored; refill always completes.
REQ-026 mem_rd_valid outside REFILL SHALL be ignored.
REQ-027 When rd_req=0, miss SHALL be 0 in IDLE and rd_data is don't-care.
REQ-028 A refill SHALL overwrite the previous line in that set unconditionally (read-only cache, no write-back).

Reset
REQ-029 rst SHALL force state IDLE, all valid bits 0, beat counter 0, mem_rd_req 0, mem_rd_addr 0, miss 0, asynchronously.
REQ-030 Reset mid-refill SHALL abandon the refill; partially written line stays invalid; data array contents need no reset.

Configuration
REQ-031 Macro ICACHE_STATS_EN defined: outputs hit_count and miss_count (32 bits each, wrapping) exist; hit_count +1 per IDLE cycle with rd_req && hit; miss_count +1 per IDLE->REFILL transition; both reset to 0.
REQ-032 Macro ICACHE_STATS_EN undefined: those ports and counters are absent; all other behaviour identical.

Verification
REQ-033 Reset, rd_req=1 addr=0x0 -> miss=1, mem_rd_req=1 mem_rd_addr=0x0; 8 beats 0x00404713.. -> FILL_DONE, then miss=0 rd_data=0x00404713.
REQ-034 After fill, addr=0x1..0x7 back-to-back -> miss=0 every cycle, rd_data equals beat 1..7 data, mem_rd_req stays 0.
REQ-035 Conflict: addr=0x80 (same set 0, tag 1) -> miss=1, mem_rd_addr=0x80; after refill, addr=0x0 misses again.
REQ-036 During REFILL, addr toggles to 0x40 and rd_req drops, mem_rd_valid gaps of 3 cycles -> mem_rd_addr stays 0x0, exactly 8 words written, completes.
REQ-037 rst pulsed after 4 of 8 beats -> mem_rd_req=0 immediately; addr=0x0 then misses with fresh refill from beat 0.
REQ-038 With ICACHE_STATS_EN: sequence of REQ-033 then REQ-034 -> miss_count=1, hit_count=8.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Core-fetch and backing-memory refill signals of the direct-mapped instruction cache.
interface icache_refill_ctrl_if;
  logic        rd_req;
  logic [29:0] addr;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_rd_req;
  logic [29:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  modport slave (
    input  rd_req, addr, mem_rd_valid, mem_rd_data,
    output rd_data, miss, mem_rd_req, mem_rd_addr
  );

  modport master (
    output rd_req, addr, mem_rd_valid, mem_rd_data,
    input  rd_data, miss, mem_rd_req, mem_rd_addr
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped read-only instruction cache with zero-latency hits and line refill FSM.
// Define ICACHE_STATS_EN to add wrapping hit_count / miss_count outputs.
module icache_refill_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  icache_refill_ctrl_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int WORDS   = 1 << LINE_ADDR_LEN;
  localparam int SETS    = 1 << SET_ADDR_LEN;

  // IDLE: serve hits / detect miss | REFILL: collect beats | FILL_DONE: one settle cycle
  typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

  state_t                   state;
  logic [SETS-1:0]          valid_q;
  logic [TAG_LEN-1:0]       tag_q  [SETS];
  logic [31:0]              data_q [SETS][WORDS];
  logic [LINE_ADDR_LEN-1:0] beat_cnt;
  logic                     mem_rd_req_q;
  logic [29:0]              mem_rd_addr_q;

  logic [TAG_LEN-1:0]       req_tag;
  logic [SET_ADDR_LEN-1:0]  req_set;
  logic [LINE_ADDR_LEN-1:0] req_word;
  logic [TAG_LEN-1:0]       fill_tag;
  logic [SET_ADDR_LEN-1:0]  fill_set;
  logic                     hit;
  logic                     fill_we;

  assign req_tag  = bus.addr[29 -: TAG_LEN];
  assign req_set  = bus.addr[LINE_ADDR_LEN +: SET_ADDR_LEN];
  assign req_word = bus.addr[LINE_ADDR_LEN-1:0];
  assign fill_tag = mem_rd_addr_q[29 -: TAG_LEN];
  assign fill_set = mem_rd_addr_q[LINE_ADDR_LEN +: SET_ADDR_LEN];

  assign hit     = valid_q[req_set] && (tag_q[req_set] == req_tag);
  assign fill_we = (state == REFILL) && bus.mem_rd_valid;

  assign bus.miss        = !rst && ((state != IDLE) || (bus.rd_req && !hit));
  assign bus.rd_data     = data_q[req_set][req_word];
  assign bus.mem_rd_req  = mem_rd_req_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid_q       <= '0;
      beat_cnt      <= '0;
      mem_rd_req_q  <= 1'b0;
      mem_rd_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.rd_req && !hit) begin
            state         <= REFILL;
            mem_rd_req_q  <= 1'b1;
            mem_rd_addr_q <= {bus.addr[29:LINE_ADDR_LEN], {LINE_ADDR_LEN{1'b0}}};
            // Old line is being overwritten; keep it invalid until the last beat lands.
            valid_q[req_set] <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.mem_rd_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (&beat_cnt) begin
              valid_q[fill_set] <= 1'b1;
              mem_rd_req_q      <= 1'b0;
              state             <= FILL_DONE;
            end
          end
        end
        FILL_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; validity alone decides whether contents are used.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_set][beat_cnt] <= bus.mem_rd_data;
      if (&beat_cnt) tag_q[fill_set] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && bus.rd_req) begin
      if (hit) hit_count  <= hit_count + 1'b1;
      else     miss_count <= miss_count + 1'b1;
    end
  end
`endif

endmodule
